// File: rtl/wb_arbiter_rr.sv
// ============================================================================
//  Module   : wb_arbiter_rr
//  Purpose  : N-master to 1-slave Wishbone B3 arbiter with a registered
//             round-robin grant and a stalled-strobe watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter_rr #(
   parameter int NUM_MASTERS = 2,
   parameter int aw          = 32,
   parameter int dw          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [NUM_MASTERS*aw-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*dw-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*dw/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]      wbm_we_i,
   input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
   output logic [NUM_MASTERS*dw-1:0]   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]      wbm_ack_o,
   output logic [NUM_MASTERS-1:0]      wbm_err_o,
   output logic [NUM_MASTERS-1:0]      wbm_rty_o,
   output logic [aw-1:0]               wbs_adr_o,
   output logic [dw-1:0]               wbs_dat_o,
   output logic [dw/8-1:0]             wbs_sel_o,
   output logic                        wbs_we_o,
   output logic                        wbs_cyc_o,
   output logic                        wbs_stb_o,
   output logic [2:0]                  wbs_cti_o,
   output logic [1:0]                  wbs_bte_o,
   input  logic [dw-1:0]               wbs_dat_i,
   input  logic                        wbs_ack_i,
   input  logic                        wbs_err_i,
   input  logic                        wbs_rty_i,
   output logic [NUM_MASTERS-1:0]      grant_o
);

   localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_MASTERS - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                   r_state;
   logic [NUM_MASTERS-1:0]   r_grant;
   logic [c_IDX_W-1:0]       r_gidx;
   logic [c_IDX_W-1:0]       r_last;

   logic                     w_found;
   logic [c_IDX_W-1:0]       w_pick;
   logic [c_IDX_W-1:0]       w_cand;
   logic                     w_gcyc;
   logic                     w_resp;
   logic                     w_wd_err;

   // Scan starts just after the last owner so every requester is served in turn.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         w_cand = c_IDX_W'((int'(r_last) + i) % NUM_MASTERS);
         if (!w_found && wbm_cyc_i[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   assign w_gcyc = |(wbm_cyc_i & r_grant);
   assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= c_LAST_RST;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|wbm_cyc_i) begin
                  r_grant <= NUM_MASTERS'(1) << w_pick;
                  r_gidx  <= w_pick;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!w_gcyc) begin
                  r_last  <= r_gidx;
                  r_grant <= '0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Grant is all-zero in IDLE, so the AND-OR mux also forces the slave side low there.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (r_grant[m]) begin
            wbs_adr_o = wbs_adr_o | wbm_adr_i[m*aw +: aw];
            wbs_dat_o = wbs_dat_o | wbm_dat_i[m*dw +: dw];
            wbs_sel_o = wbs_sel_o | wbm_sel_i[m*(dw/8) +: (dw/8)];
            wbs_we_o  = wbs_we_o  | wbm_we_i[m];
            wbs_cyc_o = wbs_cyc_o | wbm_cyc_i[m];
            wbs_stb_o = wbs_stb_o | wbm_stb_i[m];
            wbs_cti_o = wbs_cti_o | wbm_cti_i[m*3 +: 3];
            wbs_bte_o = wbs_bte_o | wbm_bte_i[m*2 +: 2];
         end
      end
   end

   assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
   assign wbm_ack_o = r_grant & {NUM_MASTERS{wbs_ack_i}};
   assign wbm_rty_o = r_grant & {NUM_MASTERS{wbs_rty_i}};
   assign wbm_err_o = r_grant & {NUM_MASTERS{wbs_err_i | w_wd_err}};
   assign grant_o   = r_grant;

   generate
      if (TIMEOUT > 0) begin : g_wdog
         localparam int c_WD_W = $clog2(TIMEOUT + 1);
         logic [c_WD_W-1:0] r_wd_cnt;
         logic              w_stall;
         logic              w_hit;

         assign w_stall  = (r_state == ST_GRANT) && wbs_stb_o && !w_resp;
         assign w_hit    = w_stall && (r_wd_cnt == c_WD_W'(TIMEOUT - 1));
         assign w_wd_err = w_hit;

         // The slave is left running; the error only tells the master to give up.
         always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
               r_wd_cnt <= '0;
            end else if (!w_stall || w_hit) begin
               r_wd_cnt <= '0;
            end else begin
               r_wd_cnt <= r_wd_cnt + 1'b1;
            end
         end
      end else begin : g_no_wdog
         assign w_wd_err = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
// ============================================================================
//  Module   : tb_wb_arbiter_rr
//  Purpose  : Self-checking bench for wb_arbiter_rr: directed scenarios plus
//             randomized traffic against a behavioural round-robin model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter_rr;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*AW-1:0] m_adr = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [N*DW/8-1:0] m_sel = '0;
   logic [N-1:0]    m_we = '0, m_cyc = '0, m_stb = '0;
   logic [N*3-1:0]  m_cti = '0;
   logic [N*2-1:0]  m_bte = '0;
   logic [N*DW-1:0] m_dat_o;
   logic [N-1:0]    m_ack, m_err, m_rty, grant;
   logic [AW-1:0]   s_adr;
   logic [DW-1:0]   s_dat_o;
   logic [DW/8-1:0] s_sel;
   logic            s_we, s_cyc, s_stb;
   logic [2:0]      s_cti;
   logic [1:0]      s_bte;
   logic [DW-1:0]   s_dat_i = '0;
   logic            s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   wb_arbiter_rr #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) u_dut (
      .wb_clk_i (clk),     .wb_rst_i (rst),
      .wbm_adr_i(m_adr),   .wbm_dat_i(m_dat),   .wbm_sel_i(m_sel),
      .wbm_we_i (m_we),    .wbm_cyc_i(m_cyc),   .wbm_stb_i(m_stb),
      .wbm_cti_i(m_cti),   .wbm_bte_i(m_bte),
      .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack),   .wbm_err_o(m_err),
      .wbm_rty_o(m_rty),
      .wbs_adr_o(s_adr),   .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel),
      .wbs_we_o (s_we),    .wbs_cyc_o(s_cyc),   .wbs_stb_o(s_stb),
      .wbs_cti_o(s_cti),   .wbs_bte_o(s_bte),
      .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack),   .wbs_err_i(s_err),
      .wbs_rty_i(s_rty),
      .grant_o  (grant)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Requester closest after the previous owner, by circular distance.
   function automatic int rr_pick(input int last, input logic [N-1:0] req);
      int best = -1;
      int bd   = N;
      for (int m = 0; m < N; m++) begin
         if (req[m]) begin
            int d;
            d = (m - last - 1 + 2*N) % N;
            if (d < bd) begin
               bd   = d;
               best = m;
            end
         end
      end
      return best;
   endfunction

   // Reference model: owner index (-1 when idle), previous owner, stalled clocks so far.
   int md_owner = -1;
   int md_last  = N - 1;
   int md_stall = 0;

   always @(negedge clk) begin : model
      logic [N-1:0]    e_grant, e_ack, e_err, e_rty;
      logic [AW-1:0]   e_adr;
      logic [DW-1:0]   e_dat;
      logic [DW/8-1:0] e_sel;
      logic [2:0]      e_cti;
      logic [1:0]      e_bte;
      logic            e_we, e_cyc, e_stb;
      bit              stalled, wd;
      int              o;
      e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
      e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0; e_bte = '0;
      e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
      stalled = 1'b0; wd = 1'b0;
      o = md_owner;
      if (!rst && o >= 0) begin
         e_grant = 4'b0001 << o;
         e_adr   = m_adr[o*AW +: AW];
         e_dat   = m_dat[o*DW +: DW];
         e_sel   = m_sel[o*(DW/8) +: (DW/8)];
         e_we    = m_we[o];
         e_cyc   = m_cyc[o];
         e_stb   = m_stb[o];
         e_cti   = m_cti[o*3 +: 3];
         e_bte   = m_bte[o*2 +: 2];
         stalled = m_stb[o] && !(s_ack || s_err || s_rty);
         wd      = (TO > 0) && stalled && (md_stall + 1 == TO);
         e_ack   = s_ack ? e_grant : '0;
         e_rty   = s_rty ? e_grant : '0;
         e_err   = (s_err || wd) ? e_grant : '0;
      end
      check_val("grant", grant, e_grant);
      check_val("s_adr", s_adr, e_adr);
      check_val("s_dat", s_dat_o, e_dat);
      check_val("s_ctl", {s_sel, s_we, s_cyc, s_stb, s_cti, s_bte},
                {e_sel, e_we, e_cyc, e_stb, e_cti, e_bte});
      check_val("m_ack", m_ack, e_ack);
      check_val("m_err", m_err, e_err);
      check_val("m_rty", m_rty, e_rty);
      for (int l = 0; l < N; l++) check_val("m_dat_o", m_dat_o[l*DW +: DW], s_dat_i);

      if (rst) begin
         md_owner = -1; md_last = N - 1; md_stall = 0;
      end else if (md_owner < 0) begin
         md_stall = 0;
         if (|m_cyc) md_owner = rr_pick(md_last, m_cyc);
      end else begin
         md_stall = (stalled && !wd) ? md_stall + 1 : 0;
         if (!m_cyc[md_owner]) begin
            md_last  = md_owner;
            md_owner = -1;
            md_stall = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_cti = '0;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin : watchdog_guard
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [N-1:0] rec_flag;
      int           rec_n;
      int           hold [N];

      do_reset();
      #1;
      check_val("rst_grant", grant, 4'b0000);
      check_val("rst_cyc", s_cyc, 1'b0);

      // Master 1 alone: 1 clock to wbs_cyc_o, ack routed to lane 1 only.
      m_cyc = 4'b0010; m_stb = 4'b0010; m_adr[63:32] = 32'h1000_0040;
      #1 check_val("s1_cyc_t0", s_cyc, 1'b0);
      tick();
      #1 check_val("s1_cyc_t1", s_cyc, 1'b1);
      check_val("s1_grant_t1", grant, 4'b0010);
      check_val("s1_adr", s_adr, 32'h1000_0040);
      tick();
      s_ack = 1'b1;
      #1 check_val("s1_ack", m_ack, 4'b0010);
      tick();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      #1 check_val("s1_rel_cyc", s_cyc, 1'b0);
      check_val("s1_rel_grant", grant, 4'b0010);
      tick();
      #1 check_val("s1_idle_grant", grant, 4'b0000);

      // Four masters always requesting, one access per grant.
      do_reset();
      m_cyc = 4'b1111; m_stb = 4'b1111; s_ack = 1'b1;
      rec_flag = '0; rec_n = 0;
      for (int c = 0; c < 80 && rec_n < 5; c++) begin
         tick();
         for (int m = 0; m < N; m++) begin
            if (grant[m] && !rec_flag[m]) begin
               check_val("rr_order", m, rec_n % N);
               rec_n++;
               rec_flag[m] = 1'b1;
            end else if (grant[m]) begin
               m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
            end else begin
               rec_flag[m] = 1'b0;
               m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
            end
         end
      end
      check_val("rr_count", rec_n, 5);

      // 8-beat incrementing burst from master 0 while master 1 waits.
      do_reset();
      m_cyc = 4'b0011; m_stb = 4'b0011; m_cti[2:0] = 3'b010; s_ack = 1'b1;
      tick();
      for (int b = 0; b < 8; b++) begin
         m_cti[2:0] = (b == 7) ? 3'b111 : 3'b010;
         #1 check_val("burst_grant", grant, 4'b0001);
         check_val("burst_cti", s_cti, (b == 7) ? 3'b111 : 3'b010);
         tick();
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      #1 check_val("burst_rel_cyc", s_cyc, 1'b0);
      tick();
      #1 check_val("burst_idle", grant, 4'b0000);
      tick();
      #1 check_val("burst_next", grant, 4'b0010);
      m_cyc = '0; m_stb = '0; s_ack = 1'b0;

      // Slave never answers: err every 4th stalled clock, then ack wins at the would-be timeout.
      do_reset();
      m_cyc = 4'b0100; m_stb = 4'b0100;
      tick();
      for (int k = 1; k <= 16; k++) begin
         s_ack = (k == 16);
         #1 check_val("wd_err", m_err, (k % 4 == 0 && k != 16) ? 4'b0100 : 4'b0000);
         if (k == 16) check_val("wd_ack_wins", m_ack, 4'b0100);
         tick();
      end
      s_ack = 1'b0;

      // Asynchronous reset while master 2 owns the bus.
      m_cti[8:6] = 3'b010;
      #1 rst = 1'b1;
      #1 check_val("arst_grant", grant, 4'b0000);
      check_val("arst_cyc", s_cyc, 1'b0);
      check_val("arst_stb", s_stb, 1'b0);
      m_cyc = 4'b0101; m_stb = 4'b0101;
      tick();
      tick();
      rst = 1'b0;
      tick();
      #1 check_val("arst_prio0", grant, 4'b0001);

      // Randomized traffic, alternating normal and stall-heavy slave phases.
      do_reset();
      for (int m = 0; m < N; m++) hold[m] = 0;
      for (int c = 0; c < 1500; c++) begin
         tick();
         rst = ($urandom_range(0, 299) == 0);
         for (int m = 0; m < N; m++) begin
            if (hold[m] > 0) begin
               hold[m]--;
               m_cyc[m] = (hold[m] > 0);
               m_stb[m] = (hold[m] > 0) && ($urandom_range(0, 3) != 0);
            end else if ($urandom_range(0, 2) == 0) begin
               hold[m]  = $urandom_range(1, 12);
               m_cyc[m] = 1'b1;
               m_stb[m] = 1'b1;
            end else begin
               m_cyc[m] = 1'b0;
               m_stb[m] = 1'b0;
            end
            m_adr[m*AW +: AW] = $urandom;
            m_dat[m*DW +: DW] = $urandom;
            m_sel[m*4 +: 4]   = 4'($urandom);
            m_we[m]           = 1'($urandom);
            m_cti[m*3 +: 3]   = 3'($urandom);
            m_bte[m*2 +: 2]   = 2'($urandom);
         end
         s_dat_i = $urandom;
         if ((c / 150) % 2 == 1) begin
            s_ack = ($urandom_range(0, 9) == 0);
            s_err = 1'b0;
            s_rty = 1'b0;
         end else begin
            int r;
            r = $urandom_range(0, 9);
            s_ack = (r < 5) || (r == 7);
            s_err = (r == 5) || (r == 7);
            s_rty = (r == 6);
         end
      end
      rst = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
